// File: rtl/div_pkg.sv
// Shared definitions for the 4-bit sequential divider: datapath width and loader FSM states.
package div_pkg;
    localparam int DIV_W = 4;

    typedef enum logic [1:0] {
        WAIT_X = 2'b00,
        WAIT_Y = 2'b01,
        PULSE  = 2'b10,
        RUN    = 2'b11
    } ld_state_e;
endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on the debounced 0->1 transition.
module btn_debounce
    import div_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);
    logic             sync1_q, sync2_q;
    logic             lvl_q, lvl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The pulse is decoded from flops only, on the cycle the level is about to flip high.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        press = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync2_q;
                press = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/operand_loader.sv
// Captures divider operands x/y from switches on debounced presses, then pulses div_reset.
// Optional zero-divisor rejection when OPERAND_ZERO_GUARD_EN is defined.
module operand_loader
    import div_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int DIV_RST_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] sw,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [DIV_W-1:0] x,
    output logic [DIV_W-1:0] y,
    output logic             div_reset,
    output logic             ready,
    output logic [1:0]       state_led,
    output logic             err
);
    localparam int PC_W = (DIV_RST_CYCLES > 1) ? $clog2(DIV_RST_CYCLES) : 1;

    logic             load_p, clr_p, zero_rej;
    ld_state_e        state_q, state_d;
    logic [DIV_W-1:0] x_q, x_d, y_q, y_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic             div_reset_q, div_reset_d, ready_q, ready_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_load (
        .clk(clk), .rst_n(reset), .btn_raw(btn_load), .press(load_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
        .clk(clk), .rst_n(reset), .btn_raw(btn_clear), .press(clr_p)
    );

`ifdef OPERAND_ZERO_GUARD_EN
    assign zero_rej = (sw == '0);
`else
    assign zero_rej = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pcnt_d  = pcnt_q;
        if (clr_p) begin
            state_d = WAIT_X;
            x_d     = '0;
            y_d     = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                WAIT_X: if (load_p) begin
                    x_d     = sw;
                    state_d = WAIT_Y;
                end
                WAIT_Y: if (load_p && !zero_rej) begin
                    y_d     = sw;
                    pcnt_d  = '0;
                    state_d = PULSE;
                end
                PULSE: begin
                    if (pcnt_q == PC_W'(DIV_RST_CYCLES - 1)) state_d = RUN;
                    else                                      pcnt_d  = pcnt_q + PC_W'(1);
                end
                RUN: if (load_p) begin
                    x_d     = sw;
                    state_d = WAIT_Y;
                end
                default: state_d = WAIT_X;
            endcase
        end
        // Outputs are registered alongside the state so they never lag it.
        div_reset_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_X;
            x_q         <= '0;
            y_q         <= '0;
            pcnt_q      <= '0;
            div_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pcnt_q      <= pcnt_d;
            div_reset_q <= div_reset_d;
            ready_q     <= ready_d;
        end
    end

`ifdef OPERAND_ZERO_GUARD_EN
    logic err_q, err_d;
    logic load_ok, load_rej;

    assign load_rej = load_p && (state_q == WAIT_Y) && zero_rej;
    assign load_ok  = load_p && (state_q != PULSE) && !load_rej;

    always_comb begin
        err_d = err_q;
        if (clr_p || load_ok) err_d = 1'b0;
        else if (load_rej)    err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign x         = x_q;
    assign y         = y_q;
    assign div_reset = div_reset_q;
    assign ready     = ready_q;
    assign state_led = state_q;
endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: table of button operations plus hand-timed corner sequences.
module tb_operand_loader;
    import div_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       btn_load = 1'b0, btn_clear = 1'b0;
    logic [3:0] x, y;
    logic       div_reset, ready, err;
    logic [1:0] state_led;

    operand_loader #(.DEBOUNCE_CYCLES(16), .CNT_W(5), .DIV_RST_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
        .x(x), .y(y), .div_reset(div_reset), .ready(ready), .state_led(state_led), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         op;     // 1 load, 2 clear, 3 load+clear together
        logic [3:0] sw;
        logic [3:0] ex, ey;
        logic [1:0] est;
        logic       edr, erd, eer;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string t, input logic [3:0] ex, input logic [3:0] ey,
                             input logic [1:0] est, input logic edr, input logic erd, input logic eer);
        chk({t, ".x"}, 32'(x), 32'(ex));
        chk({t, ".y"}, 32'(y), 32'(ey));
        chk({t, ".state"}, 32'(state_led), 32'(est));
        chk({t, ".div_reset"}, 32'(div_reset), 32'(edr));
        chk({t, ".ready"}, 32'(ready), 32'(erd));
        chk({t, ".err"}, 32'(err), 32'(eer));
    endtask

    // Hold long enough for one debounced press, then release long enough to settle.
    task automatic press(input logic ld, input logic cl, input logic [3:0] v);
        sw = v;
        btn_load = ld;
        btn_clear = cl;
        repeat (18) tick();
        btn_load = 1'b0;
        btn_clear = 1'b0;
        repeat (20) tick();
    endtask

    function automatic vec_t mk(input int op, input logic [3:0] s, input logic [3:0] ex, input logic [3:0] ey,
                                input logic [1:0] st, input logic dr, input logic rd, input logic er);
        vec_t v;
        v.op = op; v.sw = s; v.ex = ex; v.ey = ey; v.est = st; v.edr = dr; v.erd = rd; v.eer = er;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk(1, 4'd9,  4'd9,  4'd0, 2'b01, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1, 4'd3,  4'd9,  4'd3, 2'b11, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1, 4'd12, 4'd12, 4'd3, 2'b01, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1, 4'd5,  4'd12, 4'd5, 2'b11, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(2, 4'd8,  4'd0,  4'd0, 2'b00, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1, 4'd7,  4'd7,  4'd0, 2'b01, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(3, 4'd4,  4'd0,  4'd0, 2'b00, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1, 4'd5,  4'd5,  4'd0, 2'b01, 1'b1, 1'b0, 1'b0));
`ifdef OPERAND_ZERO_GUARD_EN
        tbl.push_back(mk(1, 4'd0,  4'd5,  4'd0, 2'b01, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1, 4'd2,  4'd5,  4'd2, 2'b11, 1'b0, 1'b1, 1'b0));
`else
        tbl.push_back(mk(1, 4'd0,  4'd5,  4'd0, 2'b11, 1'b0, 1'b1, 1'b0));
`endif
        tbl.push_back(mk(2, 4'd1,  4'd0,  4'd0, 2'b00, 1'b1, 1'b0, 1'b0));

        repeat (3) tick();
        check_all("reset", 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i].op[0], tbl[i].op[1], tbl[i].sw);
            check_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].est, tbl[i].edr, tbl[i].erd, tbl[i].eer);
        end

        // Capture latency and PULSE length
        press(1'b1, 1'b0, 4'd9);
        sw = 4'd3;
        btn_load = 1'b1;
        repeat (17) tick();
        check_all("pre_y", 4'd9, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("pulse1", 4'd9, 4'd3, 2'b10, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("pulse2", 4'd9, 4'd3, 2'b10, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("run", 4'd9, 4'd3, 2'b11, 1'b0, 1'b1, 1'b0);
        btn_load = 1'b0;
        repeat (20) tick();

        // Reload from RUN
        sw = 4'd12;
        btn_load = 1'b1;
        repeat (17) tick();
        check_all("run_hold", 4'd9, 4'd3, 2'b11, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("reload", 4'd12, 4'd3, 2'b01, 1'b1, 1'b0, 1'b0);
        btn_load = 1'b0;
        repeat (20) tick();

        // Bouncy press, then a clean held level
        press(1'b0, 1'b1, 4'd0);
        sw = 4'd6;
        for (int i = 0; i < 40; i++) begin
            btn_load = ((i / 3) % 2 == 0);
            tick();
        end
        chk("bounce.x", 32'(x), 32'd0);
        btn_load = 1'b1;
        repeat (17) tick();
        check_all("bounce_pre", 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        check_all("bounce_cap", 4'd6, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0);
        repeat (30) tick();
        check_all("bounce_hold", 4'd6, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0);
        btn_load = 1'b0;
        repeat (20) tick();

        // Load and clear together while waiting for y
        press(1'b1, 1'b1, 4'd9);
        check_all("coincide", 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while in PULSE
        press(1'b1, 1'b0, 4'd4);
        sw = 4'd7;
        btn_load = 1'b1;
        repeat (18) tick();
        check_all("in_pulse", 4'd4, 4'd7, 2'b10, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_all("async_rst", 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        btn_load = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        repeat (25) tick();
        check_all("post_rst", 4'd0, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
